main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm.sv | 159 +++++++++++++++
 tb/tb_main_fsm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle processor main control FSM.
// Sequences fetch/decode/memory/execute/writeback and drives datapath mux selects
// and write strobes. Outputs are Moore except IRWrite/NextPC, which also follow
// MemReady when memory wait states are enabled.
// Optional feature: define MAIN_FSM_WAIT_EN to make FETCH, MEMREAD and MEMWRITE
// hold while MemReady=0. Without it MemReady is ignored and every state lasts one cycle.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    state_e state_q, state_d;
    logic   mem_ready;

`ifdef MAIN_FSM_WAIT_EN
    assign mem_ready = MemReady;
`else
    // Memory always completes in one cycle; MemReady is deliberately ignored.
    logic unused_mem_ready;
    assign mem_ready        = 1'b1;
    assign unused_mem_ready = MemReady;
`endif

    // Only the I and L bits of Funct steer the sequence.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Op/Funct are only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; unused codes 10-15 leave every output at 0.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            StFetch: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Strobes stay low while reset is held, even though FETCH is forced.
                IRWrite   = reset & mem_ready;
                NextPC    = reset & mem_ready;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
                MemW      = 1'b1;
            end
            StExecR: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b00;
                ALUOp   = 1'b1;
            end
            StExecI: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            StAluWb: begin
                ResultSrc = 2'b00;
                RegW      = 1'b1;
            end
            StBranch: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: a driver issues random instructions and pushes the
// expected per-cycle outputs; a monitor pops and compares against the DUT.
module tb_main_fsm;

`ifdef MAIN_FSM_WAIT_EN
    localparam bit WaitMode = 1'b1;
`else
    localparam bit WaitMode = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .State     (State)
    );

    // {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
    typedef logic [15:0] rec_t;

    rec_t       exp_q[$];
    rec_t       mon_exp, mon_act;
    int         n_cmp = 0;
    int         n_bad = 0;
    event       sample_ev;
    int         plan[$];
    logic [1:0] ins_op;
    logic [5:0] ins_funct;
    bit         force_load = 1'b0;
    int         guard;

    // Expected outputs for a state, straight from the per-state control table.
    function automatic rec_t exp_out(input int st, input bit mr, input bit rst_low);
        logic irw, npc, regw, memw, br, aluop, adr, srca;
        logic [1:0] srcb, res;
        logic [3:0] s4;
        {irw, npc, regw, memw, br, aluop, adr, srca} = 8'h00;
        srcb = 2'b00;
        res  = 2'b00;
        s4   = st[3:0];
        case (st)
            0: begin
                srca = 1'b1; srcb = 2'b10; res = 2'b10;
                irw  = !rst_low && (!WaitMode || mr);
                npc  = irw;
            end
            1: begin srca = 1'b1; srcb = 2'b10; res = 2'b10; end
            2: begin srcb = 2'b01; end
            3: begin adr = 1'b1; end
            4: begin res = 2'b01; regw = 1'b1; end
            5: begin adr = 1'b1; memw = 1'b1; end
            6: begin aluop = 1'b1; end
            7: begin aluop = 1'b1; srcb = 2'b01; end
            8: begin regw = 1'b1; end
            9: begin srcb = 2'b01; res = 2'b10; br = 1'b1; end
            default: ;
        endcase
        return {s4, irw, npc, regw, memw, br, aluop, adr, srca, srcb, res};
    endfunction

    // Direct comparison of the live outputs against one expected record.
    task automatic check_now(input rec_t e, input string what);
        rec_t a;
        a = {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h required %h (State got %0d required %0d)",
                     what, $time, a, e, a[15:12], e[15:12]);
        end
    endtask

    // Pick an instruction and list the states it walks through, one entry per state.
    task automatic new_instr();
        if (force_load) begin
            ins_op    = 2'b01;
            ins_funct = 6'($urandom_range(0, 63)) | 6'b000001;
        end else begin
            ins_op    = 2'($urandom_range(0, 3));
            ins_funct = 6'($urandom_range(0, 63));
        end
        plan.push_back(0);
        plan.push_back(1);
        case (ins_op)
            2'b00: begin
                plan.push_back(ins_funct[5] ? 7 : 6);
                plan.push_back(8);
            end
            2'b01: begin
                plan.push_back(2);
                if (ins_funct[0]) begin
                    plan.push_back(3);
                    plan.push_back(4);
                end else begin
                    plan.push_back(5);
                end
            end
            2'b10: plan.push_back(9);
            default: ;
        endcase
    endtask

    // One clock cycle of stimulus; entered and left at a falling edge.
    task automatic do_cycle(input bit force_rdy);
        int st;
        bit rdy;
        if (plan.size() == 0) new_instr();
        st  = plan[0];
        rdy = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        MemReady = rdy;
        if (st == 1 || st == 2) begin
            Op    = ins_op;
            Funct = ins_funct;
        end else begin
            // Instruction bits are irrelevant outside DECODE/MEMADR; scramble them.
            Op    = 2'($urandom_range(0, 3));
            Funct = 6'($urandom_range(0, 63));
        end
        exp_q.push_back(exp_out(st, rdy, 1'b0));
        #2 -> sample_ev;
        if (!(WaitMode && (st == 0 || st == 3 || st == 5) && !rdy)) void'(plan.pop_front());
        @(negedge clk);
    endtask

    // Monitor: compare every presented output sample against the scoreboard.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {State, IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
                           ALUSrcA, ALUSrcB, ResultSrc};
                n_cmp++;
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL outputs at %0t: got %h required %h (State got %0d required %0d)",
                             $time, mon_act, mon_exp, mon_act[15:12], mon_exp[15:12]);
                end
            end
        end
    end

    // Driver: reset checks, random instruction stream, async reset in MEMREAD, recovery.
    initial begin
        reset    = 1'b0;
        Op       = 2'b00;
        Funct    = 6'd0;
        MemReady = 1'b0;
        #2;
        check_now(exp_out(0, 1'b0, 1'b1), "reset state");
        @(posedge clk);
        #1;
        MemReady = 1'b1;
        check_now(exp_out(0, 1'b1, 1'b1), "reset held over edge");
        @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 400; c++) do_cycle(1'b0);
        while (plan.size() != 0) do_cycle(1'b0);

        // Walk a load up to MEMREAD, then pull reset mid-cycle.
        force_load = 1'b1;
        guard      = 0;
        while (!(plan.size() > 0 && plan[0] == 3) && guard < 20) begin
            do_cycle(1'b1);
            guard++;
        end
        MemReady = 1'b1;
        #2;
        check_now(exp_out(3, 1'b1, 1'b0), "memread before async reset");
        #1 reset = 1'b0;
        #1;
        check_now(exp_out(0, 1'b1, 1'b1), "async reset in memread");
        @(posedge clk);
        #1;
        check_now(exp_out(0, 1'b1, 1'b1), "reset held after memread");
        @(negedge clk);
        reset      = 1'b1;
        force_load = 1'b0;
        plan.delete();

        for (int c = 0; c < 150; c++) do_cycle(1'b0);
        while (plan.size() != 0) do_cycle(1'b0);

        // Fetch wait: MemReady low for three cycles, then high.
        Op    = 2'b00;
        Funct = 6'd0;
        if (WaitMode) begin
            for (int w = 0; w < 3; w++) begin
                MemReady = 1'b0;
                #2;
                check_now(exp_out(0, 1'b0, 1'b0), "fetch wait");
                @(negedge clk);
            end
            MemReady = 1'b1;
            #2;
            check_now(exp_out(0, 1'b1, 1'b0), "expired wait");
            @(negedge clk);
            #2;
            check_now(exp_out(1, 1'b1, 1'b0), "decode after wait");
        end else begin
            MemReady = 1'b0;
            #2;
            check_now(exp_out(0, 1'b0, 1'b0), "fetch ignores MemReady");
            @(negedge clk);
            #2;
            check_now(exp_out(1, 1'b0, 1'b0), "decode after fetch");
        end

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
